mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one unified, variable-latency memory port between the instruction-fetch requester (I) and the load/store requester (D) of the RISC-V core.
- Sits between the core datapath and the single memory model. Allows one outstanding transaction at a time.
- D has fixed priority over I, with a starvation guard so that I cannot be locked out.

Parameters:
- AW, 32, address width in bits
- DW, 32, data width in bits
- STARVE_MAX, 4, consecutive D grants allowed while I is waiting (minimum 1)

Ports:
- clk  in  1  clock; rising-edge active
- rst  in  1  asynchronous reset, active-low
- i_req  in  1  fetch request
- i_addr  in  AW  fetch address
- i_gnt  out  1  fetch request accepted (1-cycle pulse)
- i_rvalid  out  1  fetch data valid (1-cycle pulse)
- i_rdata  out  DW  fetch data
- d_req  in  1  load/store request
- d_we  in  1  1 = store, 0 = load
- d_addr  in  AW  load/store address
- d_wdata  in  DW  store data
- d_gnt  out  1  load/store request accepted (1-cycle pulse)
- d_rvalid  out  1  load data valid / store complete (1-cycle pulse)
- d_rdata  out  DW  load data
- m_req  out  1  memory request; held until m_ack
- m_we  out  1  memory write enable
- m_addr  out  AW  memory address
- m_wdata  out  DW  memory write data
- m_ack  in  1  memory done (1-cycle pulse); m_rdata valid in the same cycle
- m_rdata  in  DW  memory read data

Behaviour:
- Reset (rst low, asynchronous) drives:
  - state = IDLE, starve_cnt = 0
  - i_gnt, d_gnt, i_rvalid, d_rvalid, m_req, m_we = 0
  - m_addr, m_wdata, i_rdata, d_rdata = 0
- States:
  - IDLE: arbitrate. i_gnt/d_gnt are combinational from the requests and state. The winner's addr/we/wdata are registered into the m_* outputs, the owner is registered, and the block moves to ISSUE.
  - ISSUE: m_req = 1 with stable m_* outputs. On m_ack, register m_rdata into the owner's rdata and move to RESP.
  - RESP: the owner's rvalid = 1 for exactly one cycle, then return to IDLE. There is no arbitration in RESP.
- Arbitration in IDLE:
  - If d_req and (not i_req or starve_cnt < STARVE_MAX), grant D.
  - Otherwise, if i_req, grant I.
  - If neither is requesting, stay in IDLE.
  - Exactly one gnt at most per cycle; never any gnt outside IDLE.
- Starvation counter:
  - Increments on a D grant while i_req = 1.
  - Clears on an I grant, or on any IDLE cycle with i_req = 0.
  - Saturates at STARVE_MAX.
- Handshake:
  - A requester holds req and its fields stable until gnt. It may drop req in the cycle after gnt.
  - Fields are sampled only in the gnt cycle.
- Latency: with gnt at cycle T, m_req is high from T+1. If m_ack arrives at cycle A, rvalid is at A+1. Best case (A = T+1) gives rvalid at T+2; IDLE is re-entered at A+2.
- Stores: d_rvalid pulses on completion, and d_rdata is loaded with 0.
- rdata outputs hold their last value between rvalid pulses.
- m_ack outside ISSUE is ignored.
- m_req never drops before m_ack; there is no timeout.
- Reset mid-transaction: the transaction is abandoned, m_req drops asynchronously, and no rvalid is issued. Requesters must reissue.

Optional Feature:
- Macro: MEM_ARB_STATS_EN.
- Defined: adds output ports stall_i_cnt (32) and stall_d_cnt (32).
  - Each counts cycles with its req = 1 and its gnt = 0.
  - Saturating at all ones; cleared by reset.
- Undefined: these ports and counters do not exist. All other behaviour is identical.

Decomposition:
- Package mem_arb_pkg holds:
  - the state enum: IDLE, ISSUE, RESP
  - the owner enum: OWN_I, OWN_D
  - the default constants for AW, DW and STARVE_MAX
- One natural sub-module, mem_arb_pick: combinational grant select from i_req, d_req and starve_cnt. It returns the grant vector and the owner.

Test Plan:
- Single fetch: i_req with i_addr=0x0000_0010; m_ack 3 cycles after m_req rises with m_rdata=0x0051_0113 -> i_gnt pulses once, m_addr=0x10 and m_we=0, i_rvalid one cycle after m_ack, i_rdata=0x0051_0113.
- Simultaneous requests: i_req and d_req (store, addr=0x100, wdata=0xDEAD_BEEF) in the same cycle -> d_gnt first, m_we=1, m_wdata=0xDEAD_BEEF, d_rvalid with d_rdata=0; then i_gnt in the next IDLE.
- Starvation: d_req and i_req held high continuously, STARVE_MAX=4 -> grant order D,D,D,D,I,D,D,D,D,I.
- Slow memory: m_ack delayed 20 cycles -> m_req and m_addr stable throughout, no gnt during ISSUE. A spurious m_ack injected in IDLE -> no rvalid.
- Reset mid-ISSUE: assert rst low between clock edges -> m_req=0 immediately, no rvalid afterwards; after release, a fresh i_req is served normally.
- MEM_ARB_STATS_EN defined: i_req stalled for 7 cycles behind a D transaction -> stall_i_cnt=7, stall_d_cnt=0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and default sizes for the I/D memory port arbiter.
// Included by mem_arb_pick and mem_port_arbiter.
package mem_arb_pkg;

  localparam int AW_DEF         = 32;
  localparam int DW_DEF         = 32;
  localparam int STARVE_MAX_DEF = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  typedef struct packed {
    logic d;
    logic i;
  } gnt_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational grant select: D wins unless I has waited through STARVE_MAX D grants.
// Grants are produced only while en (arbiter idle) is high.
module mem_arb_pick
  import mem_arb_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEF,
  parameter int CW         = $clog2(STARVE_MAX + 1)
) (
  input  logic          en,
  input  logic          i_req,
  input  logic          d_req,
  input  logic [CW-1:0] starve_cnt,
  output gnt_t          gnt,
  output owner_t        owner
);

  localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

  always_comb begin
    // NOTE: every output gets a default first, so no path leaves one unassigned and no latch is inferred.
    gnt   = '0;
    owner = OWN_I;
    if (en) begin
      if (d_req && (!i_req || (starve_cnt < STARVE_LIM))) begin
        gnt.d = 1'b1;
        owner = OWN_D;
      end else if (i_req) begin
        gnt.i = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one variable-latency memory port between fetch (I) and load/store (D), one transaction in flight.
// Optional stall counters are enabled with the MEM_ARB_STATS_EN macro.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW         = AW_DEF,
  parameter int DW         = DW_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_gnt,
  output logic          i_rvalid,
  output logic [DW-1:0] i_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic          m_req,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic          m_ack,
  input  logic [DW-1:0] m_rdata
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [31:0]   stall_i_cnt,
  output logic [31:0]   stall_d_cnt
`endif
);

  localparam int            CW         = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

  state_t        state, state_nxt;
  owner_t        owner, owner_sel;
  gnt_t          gnt;
  logic [CW-1:0] starve_cnt;
  logic          in_idle;
  logic          ack_take;

  assign in_idle  = (state == IDLE);
  assign ack_take = (state == ISSUE) && m_ack;

  mem_arb_pick #(
    .STARVE_MAX(STARVE_MAX),
    .CW        (CW)
  ) u_pick (
    .en        (in_idle),
    .i_req     (i_req),
    .d_req     (d_req),
    .starve_cnt(starve_cnt),
    .gnt       (gnt),
    .owner     (owner_sel)
  );

  // Decoded from state so reset removes m_req without waiting for a clock edge.
  assign i_gnt    = gnt.i;
  assign d_gnt    = gnt.d;
  assign m_req    = (state == ISSUE);
  assign i_rvalid = (state == RESP) && (owner == OWN_I);
  assign d_rvalid = (state == RESP) && (owner == OWN_D);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (gnt.i || gnt.d) state_nxt = ISSUE;
      ISSUE:   if (m_ack) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst) begin
      state <= IDLE;
      owner <= OWN_I;
    end else begin
      state <= state_nxt;
      if (gnt.i || gnt.d) owner <= owner_sel;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_we    <= 1'b0;
      m_addr  <= '0;
      m_wdata <= '0;
    end else if (gnt.d) begin
      m_we    <= d_we;
      m_addr  <= d_addr;
      m_wdata <= d_wdata;
    end else if (gnt.i) begin
      m_we    <= 1'b0;
      m_addr  <= i_addr;
      m_wdata <= '0;
    end
  end

  // Stores complete with zero data; rdata otherwise holds between responses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      i_rdata <= '0;
      d_rdata <= '0;
    end else if (ack_take) begin
      if (owner == OWN_I) i_rdata <= m_rdata;
      else                d_rdata <= m_we ? '0 : m_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt <= '0;
    end else if (in_idle) begin
      if (gnt.i || !i_req)
        starve_cnt <= '0;
      else if (gnt.d && (starve_cnt != STARVE_LIM))
        starve_cnt <= starve_cnt + CW'(1);
    end
  end

`ifdef MEM_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_i_cnt <= '0;
      stall_d_cnt <= '0;
    end else begin
      if (i_req && !gnt.i && (stall_i_cnt != '1)) stall_i_cnt <= stall_i_cnt + 32'd1;
      if (d_req && !gnt.d && (stall_d_cnt != '1)) stall_d_cnt <= stall_d_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a table of single transactions plus hand-written
// sequences for starvation, slow memory, reset mid-transaction and (with MEM_ARB_STATS_EN) stall counters.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_gnt;
  logic        i_rvalid;
  logic [31:0] i_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        m_req;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic        m_ack;
  logic [31:0] m_rdata;
`ifdef MEM_ARB_STATS_EN
  logic [31:0] stall_i_cnt;
  logic [31:0] stall_d_cnt;
`endif

  mem_port_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .i_req      (i_req),
    .i_addr     (i_addr),
    .i_gnt      (i_gnt),
    .i_rvalid   (i_rvalid),
    .i_rdata    (i_rdata),
    .d_req      (d_req),
    .d_we       (d_we),
    .d_addr     (d_addr),
    .d_wdata    (d_wdata),
    .d_gnt      (d_gnt),
    .d_rvalid   (d_rvalid),
    .d_rdata    (d_rdata),
    .m_req      (m_req),
    .m_we       (m_we),
    .m_addr     (m_addr),
    .m_wdata    (m_wdata),
    .m_ack      (m_ack),
    .m_rdata    (m_rdata)
`ifdef MEM_ARB_STATS_EN
    ,
    .stall_i_cnt(stall_i_cnt),
    .stall_d_cnt(stall_d_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        i_req;
    logic        d_req;
    logic        d_we;
    logic [31:0] i_addr;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] m_rdata;
    int          dly;
    logic        e_igt;
    logic        e_dgt;
    logic        e_we;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic [31:0] e_rdata;
  } vec_t;

  int          pass_cnt = 0;
  int          total_cnt = 0;
  logic [31:0] exp_i;
  logic [31:0] exp_d;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    i_req   = 1'b0;
    i_addr  = '0;
    d_req   = 1'b0;
    d_we    = 1'b0;
    d_addr  = '0;
    d_wdata = '0;
    m_ack   = 1'b0;
    m_rdata = '0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    exp_i = '0;
    exp_d = '0;
  endtask

  // One complete transaction from IDLE; expected values come from the vector.
  task automatic run_vec(input vec_t v, input int idx);
    string tag;
    tag     = $sformatf("vec%0d", idx);
    i_req   = v.i_req;
    d_req   = v.d_req;
    d_we    = v.d_we;
    i_addr  = v.i_addr;
    d_addr  = v.d_addr;
    d_wdata = v.d_wdata;
    #1;
    check({tag, "_i_gnt"}, {31'd0, i_gnt}, {31'd0, v.e_igt});
    check({tag, "_d_gnt"}, {31'd0, d_gnt}, {31'd0, v.e_dgt});
    step();
    i_req = 1'b0;
    d_req = 1'b0;
    if (!v.e_igt && !v.e_dgt) begin
      check({tag, "_idle_m_req"}, {31'd0, m_req}, 32'd0);
    end else begin
      check({tag, "_m_req"}, {31'd0, m_req}, 32'd1);
      check({tag, "_m_we"}, {31'd0, m_we}, {31'd0, v.e_we});
      check({tag, "_m_addr"}, m_addr, v.e_addr);
      if (v.e_dgt) check({tag, "_m_wdata"}, m_wdata, v.e_wdata);
      check({tag, "_no_gnt_issue"}, {30'd0, i_gnt, d_gnt}, 32'd0);
      repeat (v.dly) step();
      m_ack   = 1'b1;
      m_rdata = v.m_rdata;
      step();
      m_ack   = 1'b0;
      m_rdata = 32'hBAD0_BAD0;
      if (v.e_igt) exp_i = v.e_rdata;
      if (v.e_dgt) exp_d = v.e_rdata;
      check({tag, "_rvalid"}, {30'd0, d_rvalid, i_rvalid}, {30'd0, v.e_dgt, v.e_igt});
      check({tag, "_i_rdata"}, i_rdata, exp_i);
      check({tag, "_d_rdata"}, d_rdata, exp_d);
      step();
      check({tag, "_rvalid_off"}, {30'd0, d_rvalid, i_rvalid}, 32'd0);
    end
  endtask

  initial begin
    vec_t        vecs[6];
    vec_t        fresh;
    logic [9:0]  order;
    int          n_gnt;
    logic        ok;

    vecs[0] = '{1'b1, 1'b0, 1'b0, 32'h10, 32'h0, 32'h0, 32'h0051_0113, 3,
                1'b1, 1'b0, 1'b0, 32'h10, 32'h0, 32'h0051_0113};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 32'h0, 32'h200, 32'h1111_1111, 32'hCAFE_F00D, 0,
                1'b0, 1'b1, 1'b0, 32'h200, 32'h1111_1111, 32'hCAFE_F00D};
    vecs[2] = '{1'b1, 1'b1, 1'b1, 32'h40, 32'h100, 32'hDEAD_BEEF, 32'h1234_5678, 1,
                1'b0, 1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF, 32'h0};
    vecs[3] = '{1'b1, 1'b0, 1'b0, 32'h44, 32'h0, 32'h0, 32'h0000_0013, 2,
                1'b1, 1'b0, 1'b0, 32'h44, 32'h0, 32'h0000_0013};
    vecs[4] = '{1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 0,
                1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0};
    vecs[5] = '{1'b0, 1'b1, 1'b0, 32'h0, 32'hFFFF_FFFC, 32'h0, 32'hFFFF_FFFF, 0,
                1'b0, 1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0, 32'hFFFF_FFFF};
    fresh   = '{1'b1, 1'b0, 1'b0, 32'hA0, 32'h0, 32'h0, 32'h0000_0517, 1,
                1'b1, 1'b0, 1'b0, 32'hA0, 32'h0, 32'h0000_0517};

    // Reset values, observed while reset is held.
    rst = 1'b0;
    clear_inputs();
    #2;
    check("rst_gnt_rvalid", {28'd0, i_gnt, d_gnt, i_rvalid, d_rvalid}, 32'd0);
    check("rst_m_req_we", {30'd0, m_req, m_we}, 32'd0);
    check("rst_m_addr", m_addr, 32'd0);
    check("rst_m_wdata", m_wdata, 32'd0);
    check("rst_i_rdata", i_rdata, 32'd0);
    check("rst_d_rdata", d_rdata, 32'd0);
    do_reset();

    for (int k = 0; k < 6; k++) run_vec(vecs[k], k);

    // Both requesters held high: D gets four grants, then I once, repeating.
    i_req  = 1'b1;
    i_addr = 32'h0000_0200;
    d_req  = 1'b1;
    d_we   = 1'b0;
    d_addr = 32'h0000_0300;
    order  = '0;
    n_gnt  = 0;
    #1;
    for (int c = 0; c < 200 && n_gnt < 10; c++) begin
      if (d_gnt) begin
        order = {order[8:0], 1'b1};
        n_gnt++;
      end else if (i_gnt) begin
        order = {order[8:0], 1'b0};
        n_gnt++;
      end
      m_ack   = m_req;
      m_rdata = 32'(c);
      step();
    end
    i_req = 1'b0;
    d_req = 1'b0;
    check("starve_grant_count", 32'(n_gnt), 32'd10);
    check("starve_order_DDDDIDDDDI", {22'd0, order}, {22'd0, 10'b11110_11110});
    m_ack = 1'b1;
    step();
    m_ack = 1'b0;
    step();
    step();

    // Slow memory: 20 cycles in ISSUE with a competing D request that must not be granted.
    i_req  = 1'b1;
    i_addr = 32'h80;
    #1;
    check("slow_i_gnt", {31'd0, i_gnt}, 32'd1);
    step();
    i_req  = 1'b0;
    d_req  = 1'b1;
    d_addr = 32'h400;
    ok     = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (!m_req || (m_addr != 32'h80) || i_gnt || d_gnt || i_rvalid || d_rvalid) ok = 1'b0;
      step();
    end
    check("slow_issue_stable", {31'd0, ok}, 32'd1);
    d_req   = 1'b0;
    m_ack   = 1'b1;
    m_rdata = 32'h0000_0093;
    step();
    m_ack   = 1'b0;
    check("slow_i_rvalid", {31'd0, i_rvalid}, 32'd1);
    check("slow_i_rdata", i_rdata, 32'h0000_0093);
    step();
    // Spurious acknowledge while idle must be ignored.
    m_ack   = 1'b1;
    m_rdata = 32'h7777_7777;
    step();
    m_ack   = 1'b0;
    check("spurious_ack_rvalid", {30'd0, i_rvalid, d_rvalid}, 32'd0);
    check("spurious_ack_m_req", {31'd0, m_req}, 32'd0);
    step();
    check("spurious_ack_rvalid_late", {30'd0, i_rvalid, d_rvalid}, 32'd0);
    check("spurious_ack_i_rdata", i_rdata, 32'h0000_0093);

    // Reset asserted between edges while in ISSUE.
    i_req  = 1'b1;
    i_addr = 32'h90;
    #1;
    step();
    i_req = 1'b0;
    step();
    check("pre_rst_m_req", {31'd0, m_req}, 32'd1);
    #3 rst = 1'b0;
    #1;
    check("async_rst_m_req", {31'd0, m_req}, 32'd0);
    check("async_rst_m_addr", m_addr, 32'd0);
    m_ack   = 1'b1;
    m_rdata = 32'h5555_5555;
    step();
    step();
    m_ack = 1'b0;
    rst   = 1'b1;
    exp_i = '0;
    exp_d = '0;
    ok    = 1'b1;
    for (int c = 0; c < 4; c++) begin
      if (i_rvalid || d_rvalid || m_req) ok = 1'b0;
      step();
    end
    check("post_rst_quiet", {31'd0, ok}, 32'd1);
    check("post_rst_i_rdata", i_rdata, 32'd0);
    run_vec(fresh, 6);

`ifdef MEM_ARB_STATS_EN
    // I waits behind a D load whose ack comes on the fifth ISSUE cycle: 7 stall cycles.
    do_reset();
    i_req  = 1'b1;
    i_addr = 32'hC0;
    d_req  = 1'b1;
    d_we   = 1'b0;
    d_addr = 32'h500;
    #1;
    check("stats_d_first", {30'd0, i_gnt, d_gnt}, 32'd1);
    step();
    d_req = 1'b0;
    repeat (4) step();
    m_ack   = 1'b1;
    m_rdata = 32'h1;
    step();
    m_ack = 1'b0;
    step();
    check("stats_i_gnt", {31'd0, i_gnt}, 32'd1);
    step();
    i_req = 1'b0;
    check("stall_i_cnt", stall_i_cnt, 32'd7);
    check("stall_d_cnt", stall_d_cnt, 32'd0);
    m_ack = 1'b1;
    step();
    m_ack = 1'b0;
    step();
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
